// File: rtl/learn_player_pkg.sv
// Shared FSM state encoding, note markers and octave codes for the learn-mode player.
package learn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    REST,
    WAIT_KEY,
    HOLD,
    ADVANCE,
    DONE
  } state_t;

  // Markers are plain ints so they truncate/extend to any NOTE_W.
  localparam int NOTE_REST = 0;
  localparam int NOTE_END  = -1;

  localparam logic [1:0] OCT_MID = 2'd0;
  localparam logic [1:0] OCT_LO  = 2'd1;
  localparam logic [1:0] OCT_HI  = 2'd2;

endpackage

// File: rtl/learn_player_if.sv
// Registered-read song library port: the player drives the address, the library returns a note a cycle later.
interface learn_player_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned NOTE_W = 4,
    parameter int unsigned OCT_W  = 2,
    parameter int unsigned DUR_W  = 4
);
    logic [ADDR_W-1:0] lib_addr;
    logic [NOTE_W-1:0] lib_note;
    logic [OCT_W-1:0]  lib_oct;
    logic [DUR_W-1:0]  lib_dur;

    modport master (output lib_addr, input lib_note, lib_oct, lib_dur);
    modport slave  (input lib_addr, output lib_note, lib_oct, lib_dur);
endinterface

// File: rtl/learn_player_tick_gen.sv
// Duration prescaler: one-cycle tick every TICK_DIV enabled clk cycles, synchronous clear.
module tick_gen #(
    parameter int unsigned TICK_DIV = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/learn_player.sv
// Learn-mode song player: hints the expected key and advances only on correctly held notes.
// Optional build macro LEARN_AUTOSKIP_EN skips a note left unplayed for SKIP_TICKS ticks.
module learn_player
    import learn_pkg::*;
#(
    parameter int unsigned NUM_KEYS = 7,
    parameter int unsigned SONG_LEN = 56,
    parameter int unsigned TICK_DIV = 10000000,
    parameter int unsigned NOTE_W   = 4,
    parameter int unsigned OCT_W    = 2,
    parameter int unsigned DUR_W    = 4,
    parameter int unsigned CNT_W    = 8
`ifdef LEARN_AUTOSKIP_EN
    ,
    parameter int unsigned SKIP_TICKS = 8
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic [OCT_W-1:0]    octave_sel,
    learn_player_if.master      lib,
    output logic [NOTE_W-1:0]   note_out,
    output logic [OCT_W-1:0]    octave_out,
    output logic [NUM_KEYS-1:0] hint_led,
    output logic [CNT_W-1:0]    correct_cnt,
    output logic [CNT_W-1:0]    error_cnt,
    output logic                busy,
    output logic                done
);
    localparam int unsigned ADDR_W = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

    typedef struct packed {
        logic [NOTE_W-1:0]   note;
        logic [OCT_W-1:0]    oct;
        logic [NUM_KEYS-1:0] hint;
        logic                busy;
        logic                done;
    } out_t;

    state_t              state;
    logic                fetch_wait;
    logic                start_q;
    logic [NUM_KEYS-1:0] keys_q;
    logic [ADDR_W-1:0]   addr;
    logic [NOTE_W-1:0]   note_r;
    logic [OCT_W-1:0]    oct_r;
    logic [DUR_W-1:0]    dur_r;
    logic [NUM_KEYS-1:0] mask_r;
    logic [DUR_W-1:0]    ticks;
    out_t                outs;

    logic                start_edge;
    logic                key_ok;
    logic                wrong;
    logic                err_inc;
    logic                tick;
    logic                tick_en;
    logic                tick_clr;
    logic                lib_end;
    logic [NUM_KEYS-1:0] lib_mask;
    logic [NUM_KEYS-1:0] rise;

    assign start_edge = start && !start_q;
    assign rise       = keys & ~keys_q;
    assign key_ok     = ((keys & mask_r) != '0) && (octave_sel == oct_r);
    assign wrong      = ((rise & ~mask_r) != '0) || (((rise & mask_r) != '0) && (octave_sel != oct_r));
    assign lib_end    = (lib.lib_note == NOTE_W'(NOTE_END)) || (int'(lib.lib_note) > NUM_KEYS);
    assign lib_mask   = NUM_KEYS'(1) << (lib.lib_note - NOTE_W'(1));

    assign lib.lib_addr = addr;
    assign note_out     = outs.note;
    assign octave_out   = outs.oct;
    assign hint_led     = outs.hint;
    assign busy         = outs.busy;
    assign done         = outs.done;

`ifdef LEARN_AUTOSKIP_EN
    localparam int unsigned SKW = $clog2(SKIP_TICKS + 1);
    logic [SKW-1:0] skip_cnt;
    logic           skip_fire;
    assign skip_fire = (state == WAIT_KEY) && !key_ok && tick && (skip_cnt == SKW'(SKIP_TICKS - 1));
    assign err_inc   = (state == WAIT_KEY) && (wrong || skip_fire);
`else
    assign err_inc   = (state == WAIT_KEY) && wrong;
`endif

    // One prescaler is shared: REST freezes it on a held key, HOLD restarts it whenever the hold breaks.
    always_comb begin
        tick_en  = 1'b0;
        tick_clr = 1'b1;
        unique case (state)
            REST: begin
                tick_en  = (keys == '0);
                tick_clr = 1'b0;
            end
            HOLD: begin
                tick_en  = key_ok;
                tick_clr = !key_ok;
            end
`ifdef LEARN_AUTOSKIP_EN
            WAIT_KEY: begin
                tick_en  = 1'b1;
                tick_clr = key_ok;
            end
`endif
            default: ;
        endcase
        if (start_edge) tick_clr = 1'b1;
    end

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .en    (tick_en),
        .tick  (tick)
    );

    function automatic out_t outs_for(input state_t s, input logic [NUM_KEYS-1:0] m,
                                      input logic [NOTE_W-1:0] n, input logic [OCT_W-1:0] o);
        out_t r;
        r = '0;
        unique case (s)
            FETCH, REST, ADVANCE: r.busy = 1'b1;
            WAIT_KEY: begin
                r.busy = 1'b1;
                r.hint = m;
            end
            HOLD: begin
                r.busy = 1'b1;
                r.hint = m;
                r.note = n;
                r.oct  = o;
            end
            DONE:    r.done = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            fetch_wait  <= 1'b0;
            start_q     <= 1'b0;
            keys_q      <= '0;
            addr        <= '0;
            note_r      <= '0;
            oct_r       <= '0;
            dur_r       <= '0;
            mask_r      <= '0;
            ticks       <= '0;
            correct_cnt <= '0;
            error_cnt   <= '0;
            outs        <= '0;
`ifdef LEARN_AUTOSKIP_EN
            skip_cnt    <= '0;
`endif
        end else begin
            start_q <= start;
            keys_q  <= keys;
            if (err_inc && !start_edge && (error_cnt != '1)) error_cnt <= error_cnt + CNT_W'(1);
            if (start_edge) begin
                correct_cnt <= '0;
                error_cnt   <= '0;
                addr        <= '0;
                fetch_wait  <= 1'b0;
                state       <= FETCH;
                outs        <= outs_for(FETCH, mask_r, note_r, oct_r);
            end else begin
                unique case (state)
                    FETCH: begin
                        // First cycle presents the address; the second sees the registered library data.
                        fetch_wait <= !fetch_wait;
                        if (fetch_wait) begin
                            note_r <= lib.lib_note;
                            oct_r  <= lib.lib_oct;
                            dur_r  <= (lib.lib_dur == '0) ? DUR_W'(1) : lib.lib_dur;
                            ticks  <= '0;
`ifdef LEARN_AUTOSKIP_EN
                            skip_cnt <= '0;
`endif
                            if (lib_end) begin
                                state <= DONE;
                                outs  <= outs_for(DONE, mask_r, note_r, oct_r);
                            end else if (lib.lib_note == NOTE_W'(NOTE_REST)) begin
                                mask_r <= '0;
                                state  <= REST;
                                outs   <= outs_for(REST, '0, lib.lib_note, lib.lib_oct);
                            end else begin
                                mask_r <= lib_mask;
                                state  <= WAIT_KEY;
                                outs   <= outs_for(WAIT_KEY, lib_mask, lib.lib_note, lib.lib_oct);
                            end
                        end
                    end
                    REST: begin
                        if (tick) begin
                            if (ticks == dur_r - DUR_W'(1)) begin
                                state <= ADVANCE;
                                outs  <= outs_for(ADVANCE, mask_r, note_r, oct_r);
                            end else begin
                                ticks <= ticks + DUR_W'(1);
                            end
                        end
                    end
                    WAIT_KEY: begin
                        if (key_ok) begin
                            ticks <= '0;
                            state <= HOLD;
                            outs  <= outs_for(HOLD, mask_r, note_r, oct_r);
                        end
`ifdef LEARN_AUTOSKIP_EN
                        else if (skip_fire) begin
                            state <= ADVANCE;
                            outs  <= outs_for(ADVANCE, mask_r, note_r, oct_r);
                        end else if (tick) begin
                            skip_cnt <= skip_cnt + SKW'(1);
                        end
`endif
                    end
                    HOLD: begin
                        if (!key_ok) begin
                            ticks <= '0;
`ifdef LEARN_AUTOSKIP_EN
                            skip_cnt <= '0;
`endif
                            state <= WAIT_KEY;
                            outs  <= outs_for(WAIT_KEY, mask_r, note_r, oct_r);
                        end else if (tick) begin
                            if (ticks == dur_r - DUR_W'(1)) begin
                                if (correct_cnt != '1) correct_cnt <= correct_cnt + CNT_W'(1);
                                state <= ADVANCE;
                                outs  <= outs_for(ADVANCE, mask_r, note_r, oct_r);
                            end else begin
                                ticks <= ticks + DUR_W'(1);
                            end
                        end
                    end
                    ADVANCE: begin
                        if (addr == LAST_ADDR) begin
                            addr  <= '0;
                            state <= DONE;
                            outs  <= outs_for(DONE, mask_r, note_r, oct_r);
                        end else begin
                            addr  <= addr + ADDR_W'(1);
                            state <= FETCH;
                            outs  <= outs_for(FETCH, mask_r, note_r, oct_r);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_learn_player.sv
// Scoreboarded bench for learn_player with a registered-read song library model.
module tb_learn_player;
    import learn_pkg::*;

    localparam int unsigned NK = 7;
    localparam int unsigned SL = 4;
    localparam int unsigned TD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [NK-1:0] keys = '0;
    logic [1:0]    octave_sel = '0;
    logic [3:0]    note_out;
    logic [1:0]    octave_out;
    logic [NK-1:0] hint_led;
    logic [7:0]    correct_cnt;
    logic [7:0]    error_cnt;
    logic          busy;
    logic          done;

    learn_player_if #(.ADDR_W(2), .NOTE_W(4), .OCT_W(2), .DUR_W(4)) lib ();

    learn_player #(
        .NUM_KEYS (NK),
        .SONG_LEN (SL),
        .TICK_DIV (TD),
        .NOTE_W   (4),
        .OCT_W    (2),
        .DUR_W    (4),
        .CNT_W    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .keys        (keys),
        .octave_sel  (octave_sel),
        .lib         (lib),
        .note_out    (note_out),
        .octave_out  (octave_out),
        .hint_led    (hint_led),
        .correct_cnt (correct_cnt),
        .error_cnt   (error_cnt),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    logic [3:0] mem_note [SL];
    logic [1:0] mem_oct  [SL];
    logic [3:0] mem_dur  [SL];

    always @(posedge clk) begin
        lib.lib_note <= mem_note[lib.lib_addr];
        lib.lib_oct  <= mem_oct[lib.lib_addr];
        lib.lib_dur  <= mem_dur[lib.lib_addr];
    end

    typedef struct {
        logic [3:0] note;
        logic [1:0] oct;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         fails = 0;
    logic [3:0] prev_note = '0;

    // Every new buzzer note must match the next note the stimulus expects to be played.
    always @(negedge clk) begin
        exp_t e;
        if (note_out != '0 && prev_note == '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_note: got note %0d oct %0d, none expected", note_out, octave_out);
            end else begin
                e = exp_q.pop_front();
                if (note_out !== e.note || octave_out !== e.oct) begin
                    fails++;
                    $display("FAIL sb_note: got note %0d oct %0d, expected note %0d oct %0d",
                             note_out, octave_out, e.note, e.oct);
                end
            end
        end
        prev_note = note_out;
    end

    task automatic set_song(input logic [3:0] n0, input logic [1:0] o0, input logic [3:0] d0,
                            input logic [3:0] n1, input logic [1:0] o1, input logic [3:0] d1);
        for (int i = 0; i < int'(SL); i++) begin
            mem_note[i] = 4'hF;
            mem_oct[i]  = 2'd0;
            mem_dur[i]  = 4'd1;
        end
        mem_note[0] = n0; mem_oct[0] = o0; mem_dur[0] = d0;
        mem_note[1] = n1; mem_oct[1] = o1; mem_dur[1] = d1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_hint(input logic [NK-1:0] h, input string name);
        int n = 0;
        while (hint_led !== h && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (hint_led !== h) begin
            fails++;
            $display("FAIL %s: hint_led %b, expected %b (timed out)", name, hint_led, h);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic count_note(input logic [3:0] n, output int cnt);
        logic seen = 1'b0;
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (note_out == n) cnt++;
            if (note_out != '0) seen = 1'b1;
            else if (seen) break;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({note_out, octave_out, hint_led, correct_cnt, error_cnt, busy, done} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, expected 0",
                     {note_out, octave_out, hint_led, correct_cnt, error_cnt, busy, done});
        end
        checks++;
        if (lib.lib_addr !== 2'd0) begin
            fails++;
            $display("FAIL reset_addr: got %0d, expected 0", lib.lib_addr);
        end
        reset = 1'b1;
        @(negedge clk);
        set_song(4'd3, OCT_LO, 4'd2, 4'hF, 2'd0, 4'd1);
        pulse_start();
        wait_hint(7'b0000100, "reset_first_hint");
        exp_q.push_back('{4'd3, OCT_LO});
        keys = 7'b0000100;
        octave_sel = OCT_LO;
        repeat (3) @(negedge clk);
        checks++;
        if (note_out !== 4'd3) begin
            fails++;
            $display("FAIL reset_in_hold: note_out %0d, expected 3", note_out);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({note_out, octave_out, hint_led, correct_cnt, error_cnt, busy, done, lib.lib_addr} !== '0) begin
            fails++;
            $display("FAIL reset_mid_hold: got %h, expected 0",
                     {note_out, octave_out, hint_led, correct_cnt, error_cnt, busy, done, lib.lib_addr});
        end
        @(negedge clk);
        keys = '0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy %b done %b, expected 0 0", busy, done);
        end
        pulse_start();
        checks++;
        if (busy !== 1'b1 || lib.lib_addr !== 2'd0) begin
            fails++;
            $display("FAIL restart: busy %b addr %0d, expected 1 0", busy, lib.lib_addr);
        end
        wait_hint(7'b0000100, "restart_hint");
    endtask

    task automatic test_play();
        int c;
        pulse_start();
        wait_hint(7'b0000100, "play_hint");
        exp_q.push_back('{4'd3, OCT_LO});
        keys = 7'b0000100;
        octave_sel = OCT_LO;
        count_note(4'd3, c);
        checks++;
        if (c != 8) begin
            fails++;
            $display("FAIL play_note_len: %0d cycles, expected 8", c);
        end
        wait_done();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || correct_cnt !== 8'd1 || error_cnt !== 8'd0) begin
            fails++;
            $display("FAIL play_end: done %b busy %b correct %0d error %0d, expected 1 0 1 0",
                     done, busy, correct_cnt, error_cnt);
        end
        keys = '0;
    endtask

    task automatic test_wrong_press();
        pulse_start();
        checks++;
        if (correct_cnt !== 8'd0 || done !== 1'b0) begin
            fails++;
            $display("FAIL start_clears: correct %0d done %b, expected 0 0", correct_cnt, done);
        end
        wait_hint(7'b0000100, "wrong_hint");
        keys = 7'b0010000;
        octave_sel = OCT_HI;
        repeat (2) @(negedge clk);
        keys = 7'b0010100;
        repeat (3) @(negedge clk);
        checks++;
        if (error_cnt !== 8'd2 || hint_led !== 7'b0000100 || note_out !== 4'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL wrong_press: error %0d hint %b note %0d busy %b, expected 2 0000100 0 1",
                     error_cnt, hint_led, note_out, busy);
        end
        keys = '0;
        @(negedge clk);
        keys = 7'b1000001;
        repeat (2) @(negedge clk);
        checks++;
        if (error_cnt !== 8'd3) begin
            fails++;
            $display("FAIL simultaneous_edges: error %0d, expected 3", error_cnt);
        end
        keys = '0;
    endtask

    task automatic test_early_release();
        int c;
        octave_sel = OCT_LO;
        pulse_start();
        checks++;
        if (error_cnt !== 8'd0) begin
            fails++;
            $display("FAIL error_cleared: error %0d, expected 0", error_cnt);
        end
        wait_hint(7'b0000100, "release_hint");
        exp_q.push_back('{4'd3, OCT_LO});
        exp_q.push_back('{4'd3, OCT_LO});
        keys = 7'b0000100;
        repeat (5) @(negedge clk);
        keys = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (note_out !== 4'd0 || hint_led !== 7'b0000100 || correct_cnt !== 8'd0 || done !== 1'b0) begin
            fails++;
            $display("FAIL early_release: note %0d hint %b correct %0d done %b, expected 0 0000100 0 0",
                     note_out, hint_led, correct_cnt, done);
        end
        keys = 7'b0000100;
        count_note(4'd3, c);
        checks++;
        if (c != 8) begin
            fails++;
            $display("FAIL rehold_len: %0d cycles, expected 8", c);
        end
        wait_done();
        checks++;
        if (done !== 1'b1 || correct_cnt !== 8'd1 || error_cnt !== 8'd0) begin
            fails++;
            $display("FAIL rehold_end: done %b correct %0d error %0d, expected 1 1 0", done, correct_cnt, error_cnt);
        end
        keys = '0;
    endtask

    task automatic test_rest();
        int n;
        set_song(4'd0, OCT_MID, 4'd2, 4'hF, 2'd0, 4'd1);
        keys = 7'b0000001;
        pulse_start();
        repeat (20) @(negedge clk);
        keys = 7'b0000010;
        repeat (5) @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || hint_led !== '0 || note_out !== 4'd0) begin
            fails++;
            $display("FAIL rest_stall: done %b busy %b hint %b note %0d, expected 0 1 0 0",
                     done, busy, hint_led, note_out);
        end
        keys = '0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 11) begin
            fails++;
            $display("FAIL rest_release_latency: done after %0d cycles, expected 11", n);
        end
        checks++;
        if (error_cnt !== 8'd0) begin
            fails++;
            $display("FAIL rest_errors: error %0d, expected 0", error_cnt);
        end
    endtask

    task automatic test_full_song();
        logic [3:0]    ns [4];
        logic [1:0]    os [4];
        logic [3:0]    ds [4];
        logic [NK-1:0] h;
        int            c;
        ns = '{4'd1, 4'd2, 4'd4, 4'd7};
        os = '{OCT_MID, OCT_HI, OCT_LO, OCT_MID};
        ds = '{4'd1, 4'd1, 4'd2, 4'd0};
        for (int i = 0; i < 4; i++) begin
            mem_note[i] = ns[i];
            mem_oct[i]  = os[i];
            mem_dur[i]  = ds[i];
        end
        keys = '0;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            h = NK'(1) << (ns[i] - 4'd1);
            wait_hint(h, "full_hint");
            checks++;
            if (lib.lib_addr !== 2'(i)) begin
                fails++;
                $display("FAIL full_addr: addr %0d, expected %0d", lib.lib_addr, i);
            end
            exp_q.push_back('{ns[i], os[i]});
            keys = h;
            octave_sel = os[i];
            count_note(ns[i], c);
            checks++;
            if (c != 4 * ((ds[i] == 0) ? 1 : int'(ds[i]))) begin
                fails++;
                $display("FAIL full_note_len: note %0d held %0d cycles, expected %0d",
                         i, c, 4 * ((ds[i] == 0) ? 1 : int'(ds[i])));
            end
            keys = '0;
        end
        wait_done();
        checks++;
        if (done !== 1'b1 || correct_cnt !== 8'd4 || error_cnt !== 8'd0 || lib.lib_addr !== 2'd0) begin
            fails++;
            $display("FAIL full_end: done %b correct %0d error %0d addr %0d, expected 1 4 0 0",
                     done, correct_cnt, error_cnt, lib.lib_addr);
        end
    endtask

    initial begin
        set_song(4'hF, 2'd0, 4'd1, 4'hF, 2'd0, 4'd1);
        repeat (2) @(negedge clk);
        test_reset();
        test_play();
        test_wrong_press();
        test_early_release();
        test_rest();
        test_full_song();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: %0d expected notes never played, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/learn_player.md
Name: learn_player

Overview:
- Parametrised successor of the single-song learn-mode player.
- Steps through a song held in an external note library over a registered read port, lights the hint LED for the expected key, and advances only while the player holds the correct key at the correct octave for the note's duration.
- Adds start/restart control, wrong-press and correct-note scoring, and a done flag.
- Sits between the song library, the switch/octave inputs, and the buzzer/LED drivers.

Parameters:
- NUM_KEYS, 7: number of note keys/switches; note codes 1..NUM_KEYS map to key index code-1.
- SONG_LEN, 56: maximum notes per song; the address wraps at this limit.
- TICK_DIV, 10000000: clk cycles per duration tick.
- NOTE_W, 4: note code width; 0 = rest, all-ones = end marker.
- OCT_W, 2: octave code width.
- DUR_W, 4: duration field width, in ticks.
- CNT_W, 8: width of the score counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  rising edge begins or restarts the song at address 0.
- keys  in  NUM_KEYS  switch levels.
- octave_sel  in  OCT_W  player's selected octave.
- lib_addr  out  $clog2(SONG_LEN)  note address to the library.
- lib_note  in  NOTE_W  library note; valid 1 cycle after lib_addr.
- lib_oct  in  OCT_W  library octave; same timing as lib_note.
- lib_dur  in  DUR_W  library duration; same timing as lib_note.
- note_out  out  NOTE_W  note to the buzzer; 0 = silent.
- octave_out  out  OCT_W  octave to the buzzer.
- hint_led  out  NUM_KEYS  one-hot expected key; 0 on rest or when not playing.
- correct_cnt  out  CNT_W  notes completed correctly.
- error_cnt  out  CNT_W  wrong presses.
- busy  out  1  high while a song is in progress.
- done  out  1  high from end of song until the next start.

Behaviour:
- Reset values: all outputs 0; state IDLE; address 0; counters 0; tick prescaler 0. Reset has priority in any state.
- start is edge-detected against a registered copy. A start edge in any state clears both counters and done, sets address to 0, and goes to FETCH.
- FETCH: drive lib_addr, wait 1 cycle, latch note/oct/dur into registers.
  - dur = 0 is treated as 1 tick.
  - note = all-ones, or a code > NUM_KEYS, ends the song: go to DONE.
- REST (latched note = 0):
  - note_out = 0; hint_led = 0.
  - Ticks count only while keys == 0; any pressed key freezes the count (no error).
  - After dur ticks, go to ADVANCE.
- WAIT_KEY:
  - hint_led = one-hot(note-1); note_out = 0.
  - Correct = keys[note-1] high AND octave_sel == latched octave. Correct goes to HOLD; the prescaler and tick count clear.
  - A wrong press is a rising edge of any other key bit, or a rising edge of keys[note-1] with the wrong octave. It increments error_cnt once per edge, saturating at all-ones. Simultaneous edges in one cycle count as 1.
- HOLD:
  - note_out = latched note; octave_out = latched octave.
  - Prescaler counts clk; every TICK_DIV cycles the tick count increments.
  - If the correct condition drops before dur ticks, return to WAIT_KEY; the tick count is cleared (no partial credit).
  - When dur ticks complete: correct_cnt increments (saturating), then go to ADVANCE.
- ADVANCE: address+1; if it reaches SONG_LEN, go to DONE; else go to FETCH.
- DONE: done = 1, busy = 0, note_out = 0, hint_led = 0. Holds until a start edge.
- busy = 1 in FETCH, REST, WAIT_KEY, HOLD, ADVANCE.
- Latency:
  - start edge to first lib_addr valid: 1 cycle.
  - Latched note to hint_led: 1 cycle after lib data.
  - note_out rises the cycle after the correct key is seen.

Optional Feature:
- Macro: LEARN_AUTOSKIP_EN.
- With the macro: adds parameter SKIP_TICKS (default 8). If WAIT_KEY persists SKIP_TICKS ticks without entering HOLD, error_cnt increments and the FSM goes to ADVANCE. The timer resets on every entry to WAIT_KEY.
- Without the macro: WAIT_KEY waits indefinitely; no extra parameter or logic.

Decomposition:
- Package learn_pkg: state enum (IDLE, FETCH, REST, WAIT_KEY, HOLD, ADVANCE, DONE), NOTE_REST = 0, NOTE_END = all-ones, and the octave codes LO = 1, MID = 0, HI = 2.
- One sub-module, tick_gen: prescaler producing a 1-cycle tick pulse every TICK_DIV clk cycles, with a synchronous clear. It is reused by HOLD, REST, and the autoskip timer.

Test Plan:
- Reset mid-HOLD (TICK_DIV = 4): assert reset in HOLD, then start edge -> all outputs 0, done = 0; start restarts at address 0.
- Song {3/oct1/dur2, END}: hold keys[2] with octave_sel = 1 for 8 clk after HOLD entry -> note_out = 3 for 8 cycles, correct_cnt = 1, done = 1.
- Same song, press keys[4] then keys[2] with octave_sel = 2 -> error_cnt = 2, FSM stays in WAIT_KEY, hint_led = 7'b0000100.
- Early release: hold the correct key 1 tick, release, re-hold 2 ticks -> advance occurs only after the second full hold, correct_cnt = 1.
- Rest {0/dur2}: with a key held the rest stalls; after release, advance happens in exactly 2 ticks; error_cnt unchanged.
- SONG_LEN = 4 with no END marker, all notes played correctly -> lib_addr reaches 3, then DONE; correct_cnt = 4.
